// File: rtl/rect_priority_btree_mux.sv
// Priority-select binary tree: returns the data word of the highest-index flagged rectangle.
// Optional macro BTREE_MUX_PIPELINE_EN registers every layer (latency LEVELS) instead of only the output (latency 1).
module rect_priority_btree_mux #(
    parameter int RECT_COUNT = 64,
    parameter int LEVELS     = $clog2(RECT_COUNT),
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [RECT_COUNT-1:0] flags_in,
    input  logic [DATA_WIDTH-1:0] data_in [RECT_COUNT],
    output logic                  valid_out,
    output logic                  flag_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    for (genvar l = 0; l < LEVELS; l++) begin : g_layer
        localparam int N = RECT_COUNT >> (l + 1);

        logic                  in_valid;
        logic [2*N-1:0]        in_flag;
        logic [DATA_WIDTH-1:0] in_data [2*N];
        logic                  out_valid;
        logic [N-1:0]          out_flag;
        logic [DATA_WIDTH-1:0] out_data [N];
        logic [N-1:0]          flag_d;
        logic [DATA_WIDTH-1:0] data_d [N];

        if (l == 0) begin : g_src
            assign in_valid = valid_in;
            assign in_flag  = flags_in;
            assign in_data  = data_in;
        end else begin : g_src
            assign in_valid = g_layer[l-1].out_valid;
            assign in_flag  = g_layer[l-1].out_flag;
            assign in_data  = g_layer[l-1].out_data;
        end

        // The upper child wins whenever its flag is set, which yields highest-index priority.
        for (genvar k = 0; k < N; k++) begin : g_node
            assign flag_d[k] = in_flag[2*k] | in_flag[2*k+1];
            assign data_d[k] = in_flag[2*k+1] ? in_data[2*k+1] : in_data[2*k];
        end

`ifdef BTREE_MUX_PIPELINE_EN
        logic                  valid_q;
        logic [N-1:0]          flag_q;
        logic [DATA_WIDTH-1:0] data_q [N];

        // NOTE: the data array is reset too, because the stage contents are observable at the outputs after reset.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= 1'b0;
                flag_q  <= '0;
                for (int k = 0; k < N; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                valid_q <= in_valid;
                flag_q  <= flag_d;
                data_q  <= data_d;
            end
        end

        assign out_valid = valid_q;
        assign out_flag  = flag_q;
        assign out_data  = data_q;
`else
        assign out_valid = in_valid;
        assign out_flag  = flag_d;
        assign out_data  = data_d;
`endif
    end

`ifdef BTREE_MUX_PIPELINE_EN
    assign valid_out = g_layer[LEVELS-1].out_valid;
    assign flag_out  = g_layer[LEVELS-1].out_flag[0];
    assign data_out  = g_layer[LEVELS-1].out_data[0];
`else
    logic                  valid_d, valid_q;
    logic                  flag_d,  flag_q;
    logic [DATA_WIDTH-1:0] data_d,  data_q;

    assign valid_d = g_layer[LEVELS-1].out_valid;
    assign flag_d  = g_layer[LEVELS-1].out_flag[0];
    assign data_d  = g_layer[LEVELS-1].out_data[0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            flag_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            flag_q  <= flag_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign flag_out  = flag_q;
    assign data_out  = data_q;
`endif

endmodule

// File: tb/tb_rect_priority_btree_mux.sv
// Self-checking bench for rect_priority_btree_mux: table vectors, reset sequences,
// walking one and random traffic, all checked through a latency-aligned scoreboard.
module tb_rect_priority_btree_mux;

    localparam int RC = 64;
    localparam int DW = 6;
    localparam int LV = 6;
`ifdef BTREE_MUX_PIPELINE_EN
    localparam int LAT = LV;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [RC-1:0] flags_in;
    logic [DW-1:0] data_in [RC];
    logic          valid_out;
    logic          flag_out;
    logic [DW-1:0] data_out;

    rect_priority_btree_mux #(
        .RECT_COUNT(RC),
        .LEVELS    (LV),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .flags_in (flags_in),
        .data_in  (data_in),
        .valid_out(valid_out),
        .flag_out (flag_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic          flag;
        logic [DW-1:0] data;
    } res_t;

    typedef struct {
        string         name;
        logic [RC-1:0] flags;
        logic          inv;
        logic          exp_flag;
        logic [DW-1:0] exp_data;
    } vec_t;

    res_t  sb_q [$];
    string tag_q [$];
    vec_t  tbl [$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input res_t exp);
        check({tag, "/valid_out"}, {7'd0, valid_out}, {7'd0, exp.valid});
        check({tag, "/flag_out"},  {7'd0, flag_out},  {7'd0, exp.flag});
        check({tag, "/data_out"},  {2'd0, data_out},  {2'd0, exp.data});
    endtask

    // Reference: linear scan for the highest set index.
    function automatic res_t model(input logic v, input logic [RC-1:0] f, input logic inv);
        res_t r;
        r.valid = v;
        r.flag  = |f;
        r.data  = inv ? ~DW'(0) : DW'(0);
        for (int i = 0; i < RC; i++) begin
            if (f[i]) r.data = inv ? ~DW'(i) : DW'(i);
        end
        return r;
    endfunction

    task automatic set_data(input logic inv);
        for (int i = 0; i < RC; i++) data_in[i] = inv ? ~DW'(i) : DW'(i);
    endtask

    task automatic randomize_inputs();
        valid_in = 1'b1;
        flags_in = {$urandom, $urandom};
        for (int i = 0; i < RC; i++) data_in[i] = DW'($urandom);
    endtask

    task automatic step(input string tag, input logic v, input logic [RC-1:0] f,
                        input logic inv, input res_t exp);
        valid_in = v;
        flags_in = f;
        set_data(inv);
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() >= LAT) begin
            check_out(tag_q.pop_front(), sb_q.pop_front());
        end else begin
            check_out({tag, "/fill"}, '0);
        end
    endtask

    task automatic add_vec(input string n, input logic [RC-1:0] f, input logic inv,
                           input logic ef, input logic [DW-1:0] ed);
        vec_t t;
        t.name = n; t.flags = f; t.inv = inv; t.exp_flag = ef; t.exp_data = ed;
        tbl.push_back(t);
    endtask

    initial begin
        logic [RC-1:0] f;
        logic          v;

        add_vec("no_flags",       '0,                                      1'b0, 1'b0, 6'd0);
        add_vec("bits_3_17_40",   (64'd1 << 3) | (64'd1 << 17) | (64'd1 << 40), 1'b0, 1'b1, 6'd40);
        add_vec("all_ones",       '1,                                      1'b0, 1'b1, 6'd63);
        add_vec("bit0_only",      64'd1,                                   1'b0, 1'b1, 6'd0);
        add_vec("bit63_only",     64'd1 << 63,                             1'b0, 1'b1, 6'd63);
        add_vec("inv_no_flags",   '0,                                      1'b1, 1'b0, 6'd63);
        add_vec("inv_bits_5_62",  (64'd1 << 5) | (64'd1 << 62),            1'b1, 1'b1, 6'd1);
        add_vec("inv_bit0",       64'd1,                                   1'b1, 1'b1, 6'd63);

        reset    = 1'b0;
        valid_in = 1'b0;
        flags_in = '0;
        set_data(1'b0);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            randomize_inputs();
            @(posedge clk);
            @(negedge clk);
            check_out("in_reset", '0);
        end
        reset = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].name, 1'b1, tbl[i].flags, tbl[i].inv,
                 {1'b1, tbl[i].exp_flag, tbl[i].exp_data});
        end

        // Reset pulse while vectors are in flight: outputs clear at once and nothing leaks out later.
        for (int k = 0; k < 3; k++) begin
            f = 64'd1 << (50 + k);
            step("pre_reset", 1'b1, f, 1'b0, model(1'b1, f, 1'b0));
        end
        reset = 1'b0;
        #1;
        check_out("async_reset", '0);
        sb_q.delete();
        tag_q.delete();
        randomize_inputs();
        @(posedge clk);
        @(negedge clk);
        check_out("held_reset", '0);
        reset = 1'b1;

        for (int k = 0; k < RC; k++) begin
            f = 64'd1 << k;
            step("walk_one", 1'b1, f, 1'b0, {1'b1, 1'b1, DW'(k)});
        end

        for (int n = 0; n < 10000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       f = {$urandom, $urandom};
                1:       f = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                2:       f = 64'd1 << $urandom_range(0, RC - 1);
                default: f = ($urandom_range(0, 7) == 0) ? '0
                           : {$urandom, $urandom} & {$urandom, $urandom}
                           & {$urandom, $urandom} & {$urandom, $urandom};
            endcase
            step("random", v, f, 1'b1, model(v, f, 1'b1));
        end

        for (int k = 0; k < LAT; k++) begin
            step("drain", 1'b0, '0, 1'b0, model(1'b0, '0, 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
